conv2d_0_filter_out_arbiter: RTL and testbench

- Merges the output streams of NUM_FILTERS conv2d_0 filter cores (filter0..filterN) into one shared output FIFO.
- Each filter gets a small elastic buffer. A round-robin arbiter drains the buffers, one word per cycle, tagged with the filter index.
- Per-filter pixel counters align feature-map boundaries and raise map_done when every filter has emitted a complete map.
- Sits between the filter cores' write side and the layer output FIFO consumed by the next layer.

---
 rtl/conv2d_0_pkg.sv | 21 ++
 rtl/arb_elastic_buf.sv | 52 +++++
 rtl/conv2d_0_filter_out_arbiter.sv | 107 ++++++++++
 tb/tb_conv2d_0_filter_out_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_0_pkg.sv
// Shared constants, tagged output word and index helper for the conv2d_0 filter
// output merge path.
package conv2d_0_pkg;

  localparam int DWIDTH         = 32;
  localparam int NUM_FILTERS    = 8;
  localparam int IDW            = 3;
  localparam int BUF_DEPTH      = 4;
  localparam int PIXELS_PER_MAP = 900;

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [DWIDTH-1:0] data;
  } tagged_word_t;

  // Modular index step used for the round-robin search and pointer advance
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/arb_elastic_buf.sv
// Small register FIFO absorbing one filter core's output words until the
// arbiter drains them; writes while full and reads while empty are ignored.
module arb_elastic_buf #(
  parameter int DWIDTH    = 32,
  parameter int BUF_DEPTH = 4,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int CW = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rd,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CW'(BUF_DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv2d_0_filter_out_arbiter.sv
// Merges NUM_FILTERS filter-core streams into one output FIFO: per-filter elastic
// buffers, round-robin drain tagged with filter id, feature-map boundary alignment.
module conv2d_0_filter_out_arbiter #(
  parameter int DWIDTH         = conv2d_0_pkg::DWIDTH,
  parameter int NUM_FILTERS    = conv2d_0_pkg::NUM_FILTERS,
  parameter int IDW            = conv2d_0_pkg::IDW,
  parameter int BUF_DEPTH      = conv2d_0_pkg::BUF_DEPTH,
  parameter int PIXELS_PER_MAP = conv2d_0_pkg::PIXELS_PER_MAP
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FILTERS*DWIDTH-1:0] f_wdata,
  input  logic [NUM_FILTERS-1:0]        f_wrreq,
  output logic [NUM_FILTERS-1:0]        f_full,
  output logic [IDW+DWIDTH-1:0]         ff_wdata,
  output logic                          ff_wrreq,
  input  logic                          ff_full,
  output logic                          map_done,
  output logic [NUM_FILTERS-1:0]        overflow_err
);
  import conv2d_0_pkg::*;

  localparam int CW  = $clog2(BUF_DEPTH) + 1;
  localparam int PCW = $clog2(PIXELS_PER_MAP + 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_MAP);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(BUF_DEPTH);

  logic [DWIDTH-1:0]      buf_rdata [NUM_FILTERS];
  logic [CW-1:0]          buf_count [NUM_FILTERS];
  logic [PCW-1:0]         pixcnt    [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] buf_full;
  logic [NUM_FILTERS-1:0] buf_empty;
  logic [NUM_FILTERS-1:0] map_complete;
  logic [NUM_FILTERS-1:0] eligible;
  logic [NUM_FILTERS-1:0] grant;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         cand_idx;
  logic                   grant_valid;
  logic                   all_done;

  // A filter that finished its map stops competing until every filter has finished
  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_filter
    arb_elastic_buf #(
      .DWIDTH    (DWIDTH),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
      .clock (clock),
      .reset (reset),
      .wr    (f_wrreq[k]),
      .wdata (f_wdata[k*DWIDTH +: DWIDTH]),
      .rd    (grant[k]),
      .rdata (buf_rdata[k]),
      .full  (buf_full[k]),
      .empty (buf_empty[k]),
      .count (buf_count[k])
    );

    assign f_full[k]       = buf_full[k];
    assign map_complete[k] = (pixcnt[k] == PIX_LAST);
    assign eligible[k]     = !buf_empty[k] && !map_complete[k];
    assign grant[k]        = grant_valid && (grant_idx == IDW'(k));
  end

  assign all_done = &map_complete;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (!ff_full) begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        cand_idx = IDW'(wrap_add(int'(rr_ptr), i, NUM_FILTERS));
        if (!grant_valid && eligible[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // Overflow is judged on the pre-read count, so a full buffer drops the word
  // even when it is being popped in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      ff_wrreq     <= 1'b0;
      ff_wdata     <= '0;
      map_done     <= 1'b0;
      overflow_err <= '0;
      for (int k = 0; k < NUM_FILTERS; k++) pixcnt[k] <= '0;
    end else begin
      ff_wrreq <= grant_valid;
      map_done <= all_done;
      if (grant_valid) begin
        rr_ptr   <= IDW'(wrap_add(int'(grant_idx), 1, NUM_FILTERS));
        ff_wdata <= {grant_idx, buf_rdata[grant_idx]};
      end
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (f_wrreq[k] && (buf_count[k] == DEPTH_C)) overflow_err[k] <= 1'b1;
        if (all_done)      pixcnt[k] <= '0;
        else if (grant[k]) pixcnt[k] <= pixcnt[k] + PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv2d_0_filter_out_arbiter.sv
// Directed bench: default 8-filter instance plus a 2-filter, 4-pixel-map instance
// for the feature-map boundary behaviour.
module tb_conv2d_0_filter_out_arbiter;
  import conv2d_0_pkg::*;

  logic         clock;
  logic         reset;
  logic [255:0] f_wdata;
  logic [7:0]   f_wrreq;
  logic [7:0]   f_full;
  logic [34:0]  ff_wdata;
  logic         ff_wrreq;
  logic         ff_full;
  logic         map_done;
  logic [7:0]   overflow_err;

  logic [63:0]  m_wdata;
  logic [1:0]   m_wrreq;
  logic [1:0]   m_full;
  logic [32:0]  m_ff_wdata;
  logic         m_ff_wrreq;
  logic         m_ff_full;
  logic         m_map_done;
  logic [1:0]   m_overflow;

  int errors = 0;
  int checks = 0;
  logic saw_wr;

  conv2d_0_filter_out_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .f_wdata      (f_wdata),
    .f_wrreq      (f_wrreq),
    .f_full       (f_full),
    .ff_wdata     (ff_wdata),
    .ff_wrreq     (ff_wrreq),
    .ff_full      (ff_full),
    .map_done     (map_done),
    .overflow_err (overflow_err)
  );

  conv2d_0_filter_out_arbiter #(
    .NUM_FILTERS    (2),
    .IDW            (1),
    .PIXELS_PER_MAP (4)
  ) dut_m (
    .clock        (clock),
    .reset        (reset),
    .f_wdata      (m_wdata),
    .f_wrreq      (m_wrreq),
    .f_full       (m_full),
    .ff_wdata     (m_ff_wdata),
    .ff_wrreq     (m_ff_wrreq),
    .ff_full      (m_ff_full),
    .map_done     (m_map_done),
    .overflow_err (m_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] wrreq, input logic [31:0] base);
    for (int k = 0; k < 8; k++) f_wdata[k*32 +: 32] = base + 32'(k);
    f_wrreq = wrreq;
  endtask

  task automatic m_drive(input logic [1:0] wrreq, input logic [31:0] d0, input logic [31:0] d1);
    m_wdata = {d1, d0};
    m_wrreq = wrreq;
  endtask

  function automatic logic [63:0] tw(input int id, input logic [31:0] d);
    tagged_word_t t;
    logic [31:0] idv;
    idv    = 32'(id);
    t.id   = idv[2:0];
    t.data = d;
    return 64'(t);
  endfunction

  function automatic logic [63:0] mw(input logic id, input logic [31:0] d);
    return 64'({id, d});
  endfunction

  initial begin
    reset = 1'b0; ff_full = 1'b0; f_wrreq = '0; f_wdata = '0;
    m_wrreq = '0; m_wdata = '0; m_ff_full = 1'b0;
    step; step;
    check("rst_ff_wrreq", 64'(ff_wrreq), 64'd0);
    check("rst_ff_wdata", 64'(ff_wdata), 64'd0);
    check("rst_map_done", 64'(map_done), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    check("rst_f_full", 64'(f_full), 64'd0);
    reset = 1'b1;
    step; step;

    $display("[TB] fairness from rr_ptr=0");
    apply_stimulus(8'hFF, 32'h100); step; f_wrreq = '0;
    check("fair0_lat", 64'(ff_wrreq), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step;
      check("fair0_wrreq", 64'(ff_wrreq), 64'd1);
      check("fair0_word", 64'(ff_wdata), tw(i, 32'h100 + 32'(i)));
    end
    step;
    check("fair0_idle", 64'(ff_wrreq), 64'd0);

    $display("[TB] single word latency");
    f_wdata[3*32 +: 32] = 32'hDEADBEEF; f_wrreq = 8'h08; step; f_wrreq = '0;
    check("single_t1", 64'(ff_wrreq), 64'd0);
    step;
    check("single_t2_wrreq", 64'(ff_wrreq), 64'd1);
    check("single_t2_word", 64'(ff_wdata), tw(3, 32'hDEADBEEF));
    step;
    check("single_t3_wrreq", 64'(ff_wrreq), 64'd0);
    check("single_t3_hold", 64'(ff_wdata), tw(3, 32'hDEADBEEF));

    apply_stimulus(8'h10, 32'h400); step; f_wrreq = '0; step;
    check("single_f4_word", 64'(ff_wdata), tw(4, 32'h404));
    step;

    $display("[TB] fairness from rr_ptr=5");
    apply_stimulus(8'hFF, 32'h200); step; f_wrreq = '0;
    for (int i = 0; i < 8; i++) begin
      step;
      check("fair5_wrreq", 64'(ff_wrreq), 64'd1);
      check("fair5_word", 64'(ff_wdata), tw((5 + i) % 8, 32'h200 + 32'((5 + i) % 8)));
    end
    step;
    check("fair5_idle", 64'(ff_wrreq), 64'd0);

    $display("[TB] backpressure");
    ff_full = 1'b1; saw_wr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      f_wdata[31:0] = 32'hA0 + 32'(n); f_wrreq = 8'h01; step;
      saw_wr |= ff_wrreq;
    end
    check("bp_full_after4", 64'(f_full), 64'h01);
    check("bp_no_ovf_yet", 64'(overflow_err), 64'h00);
    f_wdata[31:0] = 32'hA4; step; f_wrreq = '0;
    check("bp_ovf_set", 64'(overflow_err), 64'h01);
    for (int n = 0; n < 15; n++) begin
      step;
      saw_wr |= ff_wrreq;
    end
    check("bp_no_output", 64'(saw_wr), 64'd0);
    ff_full = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step;
      if (n == 0) check("bp_full_clear", 64'(f_full), 64'h00);
      check("bp_drain_wrreq", 64'(ff_wrreq), 64'd1);
      check("bp_drain_word", 64'(ff_wdata), tw(0, 32'hA0 + 32'(n)));
    end
    step;
    check("bp_no_fifth", 64'(ff_wrreq), 64'd0);

    $display("[TB] simultaneous read and write on full buffer");
    ff_full = 1'b1;
    for (int n = 0; n < 4; n++) begin
      f_wdata[2*32 +: 32] = 32'hC0 + 32'(n); f_wrreq = 8'h04; step;
    end
    check("rw_full", 64'(f_full), 64'h04);
    ff_full = 1'b0; f_wdata[2*32 +: 32] = 32'hC4; step; f_wrreq = '0;
    check("rw_ovf", 64'(overflow_err), 64'h05);
    check("rw_word0", 64'(ff_wdata), tw(2, 32'hC0));
    for (int n = 1; n < 4; n++) begin
      step;
      check("rw_word", 64'(ff_wdata), tw(2, 32'hC0 + 32'(n)));
    end
    step;
    check("rw_dropped", 64'(ff_wrreq), 64'd0);

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(8'hFF, 32'hD0); step; step; f_wrreq = '0;
    check("pre_reset_stream", 64'(ff_wrreq), 64'd1);
    reset = 1'b0; #1;
    check("ar_ff_wrreq", 64'(ff_wrreq), 64'd0);
    check("ar_ff_wdata", 64'(ff_wdata), 64'd0);
    check("ar_overflow", 64'(overflow_err), 64'd0);
    check("ar_f_full", 64'(f_full), 64'd0);
    step; step;
    reset = 1'b1;
    f_wdata[1*32 +: 32] = 32'h11; f_wdata[6*32 +: 32] = 32'h66; f_wrreq = 8'h42; step; f_wrreq = '0;
    check("ar_lat_t1", 64'(ff_wrreq), 64'd0);
    step;
    check("ar_first_wrreq", 64'(ff_wrreq), 64'd1);
    check("ar_first_word", 64'(ff_wdata), tw(1, 32'h11));
    step;
    check("ar_second_word", 64'(ff_wdata), tw(6, 32'h66));
    step;
    check("ar_idle", 64'(ff_wrreq), 64'd0);

    $display("[TB] map boundary, 2 filters, 4 pixels per map");
    m_drive(2'b11, 32'hE0, 32'hF0); step;
    check("map_lat", 64'(m_ff_wrreq), 64'd0);
    m_drive(2'b11, 32'hE1, 32'hF1); step;
    check("map_w1", 64'(m_ff_wdata), mw(1'b0, 32'hE0));
    m_drive(2'b11, 32'hE2, 32'hF2); step;
    check("map_w2", 64'(m_ff_wdata), mw(1'b1, 32'hF0));
    m_drive(2'b11, 32'hE3, 32'hF3); step;
    check("map_w3", 64'(m_ff_wdata), mw(1'b0, 32'hE1));
    m_drive(2'b01, 32'hE4, 32'h0); step;
    check("map_w4", 64'(m_ff_wdata), mw(1'b1, 32'hF1));
    m_drive(2'b01, 32'hE5, 32'h0); step;
    check("map_w5", 64'(m_ff_wdata), mw(1'b0, 32'hE2));
    m_drive(2'b00, 32'h0, 32'h0); step;
    check("map_w6", 64'(m_ff_wdata), mw(1'b1, 32'hF2));
    step;
    check("map_w7", 64'(m_ff_wdata), mw(1'b0, 32'hE3));
    step;
    check("map_w8", 64'(m_ff_wdata), mw(1'b1, 32'hF3));
    check("map_done_early", 64'(m_map_done), 64'd0);
    step;
    check("map_hold_wrreq", 64'(m_ff_wrreq), 64'd0);
    check("map_done_pulse", 64'(m_map_done), 64'd1);
    step;
    check("map_w9_wrreq", 64'(m_ff_wrreq), 64'd1);
    check("map_w9", 64'(m_ff_wdata), mw(1'b0, 32'hE4));
    check("map_done_once", 64'(m_map_done), 64'd0);
    step;
    check("map_w10", 64'(m_ff_wdata), mw(1'b0, 32'hE5));
    step;
    check("map_idle", 64'(m_ff_wrreq), 64'd0);
    check("map_no_ovf", 64'(m_overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
